// File: rtl/venom_scheduler.sv
// venom_scheduler: fire-key edge detection, cooldown and ammo gating, and
// assignment of each accepted shot to the lowest free venom projectile slot.
module venom_scheduler #(
  parameter int unsigned MAX_AMMO        = 3,
  parameter int unsigned COOLDOWN_FRAMES = 8,
  parameter int unsigned REFILL_FRAMES   = 60,
  parameter logic [7:0]  FIRE_KEY        = 8'h2C
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_tick,
  input  logic        game_active,
  input  logic [15:0] keycode,
  input  logic [1:0]  motionFlag,
  input  logic [2:0]  slot_done,
  output logic [2:0]  launch,
  output logic [1:0]  launch_dir,
  output logic [2:0]  slot_busy,
  output logic [1:0]  ammo,
  output logic        cooldown_active,
  output logic        dry_fire
);

  localparam int CD_W = $clog2(COOLDOWN_FRAMES + 1);
  localparam int RF_W = $clog2(REFILL_FRAMES + 1);

  localparam logic [1:0]      AMMO_FULL = 2'(MAX_AMMO);
  localparam logic [CD_W-1:0] CD_LOAD   = CD_W'(COOLDOWN_FRAMES);
  localparam logic [CD_W-1:0] CD_ONE    = CD_W'(1);
  localparam logic [RF_W-1:0] RF_LAST   = RF_W'(REFILL_FRAMES - 1);
  localparam logic [RF_W-1:0] RF_ONE    = RF_W'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FIRE     = 2'd1,
    COOLDOWN = 2'd2
  } stateT;

  stateT           state;
  stateT           stateNext;
  logic            keyMatch;
  logic            keyQ;
  logic            fireEdge;
  logic [2:0]      selOneHot;
  logic            canFire;
  logic            shot;
  logic            refillTick;
  logic [CD_W-1:0] cdCnt;
  logic [RF_W-1:0] rfCnt;

  assign keyMatch   = (keycode[15:8] == FIRE_KEY) | (keycode[7:0] == FIRE_KEY);
  assign fireEdge   = keyMatch & ~keyQ;
  assign canFire    = (ammo != 2'd0) && (selOneHot != 3'b000);
  assign shot       = |launch;
  assign refillTick = frame_tick && (ammo < AMMO_FULL) && (rfCnt == RF_LAST);

  assign cooldown_active = (state == COOLDOWN);

  // Previous key level; keeps tracking while the game is stopped so a held key never fires on start.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) keyQ <= 1'b0;
    else        keyQ <= keyMatch;
  end

  // Lowest-index free slot as a one-hot vector (zero when all slots are in flight).
  always_comb begin
    selOneHot = 3'b000;
    if (!slot_busy[0])      selOneHot = 3'b001;
    else if (!slot_busy[1]) selOneHot = 3'b010;
    else if (!slot_busy[2]) selOneHot = 3'b100;
  end

  // FSM state register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= stateNext;
  end

  // FSM next-state and launch/dry-fire decode; FIRE is a single-cycle state.
  always_comb begin
    stateNext = state;
    launch    = 3'b000;
    dry_fire  = 1'b0;
    case (state)
      IDLE: begin
        if (fireEdge) stateNext = FIRE;
      end
      FIRE: begin
        if (canFire) begin
          launch    = selOneHot;
          stateNext = COOLDOWN;
        end else begin
          dry_fire  = 1'b1;
          stateNext = IDLE;
        end
      end
      COOLDOWN: begin
        if (frame_tick && (cdCnt == CD_ONE)) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
    if (!game_active) begin
      stateNext = IDLE;
      launch    = 3'b000;
      dry_fire  = 1'b0;
    end
  end

  // Cooldown frame counter, loaded on a shot and counted down by frame ticks.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)                                  cdCnt <= '0;
    else if (!game_active)                       cdCnt <= '0;
    else if (shot)                               cdCnt <= CD_LOAD;
    else if ((state == COOLDOWN) && frame_tick)  cdCnt <= cdCnt - CD_ONE;
  end

  // Refill frame counter; idle at zero whenever the pool is full.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)                 rfCnt <= '0;
    else if (!game_active)      rfCnt <= '0;
    else if (ammo == AMMO_FULL) rfCnt <= '0;
    else if (refillTick)        rfCnt <= '0;
    else if (frame_tick)        rfCnt <= rfCnt + RF_ONE;
  end

  // Ammo pool: a shot and a refill on the same edge cancel out.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)            ammo <= AMMO_FULL;
    else if (!game_active) ammo <= AMMO_FULL;
    else                   ammo <= ammo - {1'b0, shot} + {1'b0, refillTick};
  end

  // Slot occupancy: retire requests clear, a launch sets the chosen free slot.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)            slot_busy <= 3'b000;
    else if (!game_active) slot_busy <= 3'b000;
    else                   slot_busy <= (slot_busy & ~slot_done) | launch;
  end

  // Launch direction captured from the heading on each accepted shot.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)    launch_dir <= 2'b00;
    else if (shot) launch_dir <= motionFlag;
  end

endmodule

// File: tb/tb_venom_scheduler.sv
// tb_venom_scheduler: directed scenarios plus randomized traffic, checked
// every cycle against a behavioural model of the fire-control rules.
module tb_venom_scheduler;

  localparam int MAXA = 3;
  localparam int CDF  = 2;
  localparam int RFF  = 7;

  logic        Clk;
  logic        Reset = 1'b0;
  logic        frame_tick = 1'b0;
  logic        game_active = 1'b1;
  logic [15:0] keycode = 16'h0000;
  logic [1:0]  motionFlag = 2'b00;
  logic [2:0]  slot_done = 3'b000;
  logic [2:0]  launch;
  logic [1:0]  launch_dir;
  logic [2:0]  slot_busy;
  logic [1:0]  ammo;
  logic        cooldown_active;
  logic        dry_fire;

  int nVec = 0;
  int nErr = 0;

  venom_scheduler #(
    .MAX_AMMO(MAXA),
    .COOLDOWN_FRAMES(CDF),
    .REFILL_FRAMES(RFF),
    .FIRE_KEY(8'h2C)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .frame_tick(frame_tick),
    .game_active(game_active),
    .keycode(keycode),
    .motionFlag(motionFlag),
    .slot_done(slot_done),
    .launch(launch),
    .launch_dir(launch_dir),
    .slot_busy(slot_busy),
    .ammo(ammo),
    .cooldown_active(cooldown_active),
    .dry_fire(dry_fire)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 waiting for a key press, 1 shot being decided, 2 cooling down
  int         mPhase = 0;
  int         mAmmo = MAXA;
  int         mCdLeft = 0;
  int         mRf = 0;
  logic [2:0] mBusy = 3'b000;
  logic [1:0] mDir = 2'b00;
  bit         mKeyQ = 1'b0;
  bit         mKm, mShot, mRefill;
  int         mSel;

  function automatic int firstFree(input logic [2:0] busy);
    for (int i = 0; i < 3; i++) if (!busy[i]) return i;
    return -1;
  endfunction

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      mPhase = 0; mAmmo = MAXA; mCdLeft = 0; mRf = 0;
      mBusy = 3'b000; mDir = 2'b00; mKeyQ = 1'b0;
    end else begin
      mKm     = (keycode[15:8] == 8'h2C) || (keycode[7:0] == 8'h2C);
      mSel    = firstFree(mBusy);
      mShot   = game_active && (mPhase == 1) && (mAmmo > 0) && (mSel >= 0);
      mRefill = frame_tick && (mAmmo < MAXA) && (mRf == RFF - 1);
      if (!game_active) begin
        mPhase = 0; mBusy = 3'b000; mAmmo = MAXA; mCdLeft = 0; mRf = 0;
      end else begin
        mBusy = mBusy & ~slot_done;
        if (mShot) begin
          mBusy[mSel] = 1'b1;
          mDir = motionFlag;
        end
        if (mAmmo == MAXA)   mRf = 0;
        else if (mRefill)    mRf = 0;
        else if (frame_tick) mRf = mRf + 1;
        mAmmo = mAmmo - int'(mShot) + int'(mRefill);
        case (mPhase)
          0: if (mKm && !mKeyQ) mPhase = 1;
          1: if (mShot) begin mPhase = 2; mCdLeft = CDF; end else mPhase = 0;
          default: if (frame_tick) begin
            mCdLeft = mCdLeft - 1;
            if (mCdLeft == 0) mPhase = 0;
          end
        endcase
      end
      mKeyQ = mKm;
    end
  end

  logic [2:0] expLaunch;
  logic       expDry;
  int         cmpSel;

  // Every-cycle comparison of all outputs against the model.
  always @(negedge Clk) begin
    expLaunch = 3'b000;
    expDry    = 1'b0;
    if (Reset && game_active && mPhase == 1) begin
      cmpSel = firstFree(mBusy);
      if (mAmmo > 0 && cmpSel >= 0) expLaunch = 3'b001 << cmpSel;
      else                          expDry = 1'b1;
    end
    check("cycle{launch,dir,busy,ammo,cd,dry}",
          {19'd0, launch, launch_dir, slot_busy, ammo, cooldown_active, dry_fire},
          {19'd0, expLaunch, mDir, mBusy, 2'(mAmmo), (mPhase == 2), expDry});
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      frame_tick = 1'b1; step();
      frame_tick = 1'b0; step();
    end
  endtask

  task automatic press(output logic [2:0] l, output logic d);
    keycode = 16'h002C; step();
    l = launch; d = dry_fire;
    step();
    keycode = 16'h0000; step();
  endtask

  logic [2:0] gotL;
  logic       gotD;
  int         nLaunch;
  logic [2:0] seenL;

  initial begin
    // reset state
    repeat (3) step();
    Reset = 1'b1;
    check("rst_ammo", 32'(ammo), 32'd3);
    check("rst_busy", 32'(slot_busy), 32'd0);
    check("rst_launch", 32'(launch), 32'd0);
    check("rst_cooldown", 32'(cooldown_active), 32'd0);
    check("rst_dry", 32'(dry_fire), 32'd0);
    step();

    // held key fires exactly once
    motionFlag = 2'b11; keycode = 16'h0000; step();
    keycode = 16'h002C; nLaunch = 0; seenL = 3'b000;
    for (int i = 0; i < 10; i++) begin
      step();
      if (launch != 3'b000) begin nLaunch++; seenL |= launch; end
    end
    check("hold_launch_count", 32'(nLaunch), 32'd1);
    check("hold_launch_slot", 32'(seenL), 32'b001);
    check("hold_dir", 32'(launch_dir), 32'b11);
    check("hold_ammo", 32'(ammo), 32'd2);
    check("hold_busy", 32'(slot_busy), 32'b001);
    check("hold_cooldown", 32'(cooldown_active), 32'd1);
    keycode = 16'h0000; step();

    // drain the pool: slots fill in index order, then a dry fire
    tick(2);
    check("cd_done", 32'(cooldown_active), 32'd0);
    press(gotL, gotD);
    check("shot2_launch", 32'(gotL), 32'b010);
    check("shot2_ammo", 32'(ammo), 32'd1);
    tick(2);
    press(gotL, gotD);
    check("shot3_launch", 32'(gotL), 32'b100);
    check("shot3_ammo", 32'(ammo), 32'd0);
    check("shot3_busy", 32'(slot_busy), 32'b111);
    tick(2);
    press(gotL, gotD);
    check("shot4_launch", 32'(gotL), 32'b000);
    check("shot4_dry", 32'(gotD), 32'd1);
    check("shot4_dry_one_cycle", 32'(dry_fire), 32'd0);
    check("shot4_ammo", 32'(ammo), 32'd0);

    // refill, then retire slot 1 and relaunch into it
    tick(1);
    check("refill_ammo", 32'(ammo), 32'd1);
    slot_done = 3'b010; step(); slot_done = 3'b000;
    check("retire_busy", 32'(slot_busy), 32'b101);
    press(gotL, gotD);
    check("retire_launch", 32'(gotL), 32'b010);
    check("retire_ammo", 32'(ammo), 32'd0);

    // shot and refill on the same edge
    tick(2); tick(4); tick(1);
    check("refill2_ammo", 32'(ammo), 32'd1);
    slot_done = 3'b001; step(); slot_done = 3'b000;
    tick(6);
    keycode = 16'h002C; step();
    check("collide_launch", 32'(launch), 32'b001);
    frame_tick = 1'b1; step();
    frame_tick = 1'b0; keycode = 16'h0000;
    check("collide_ammo", 32'(ammo), 32'd1);
    tick(6);
    check("collide_rf_cleared", 32'(ammo), 32'd1);
    tick(1);
    check("collide_next_refill", 32'(ammo), 32'd2);

    // game_active drop during cooldown flushes everything
    game_active = 1'b0; step(); game_active = 1'b1; step();
    press(gotL, gotD);
    tick(2);
    press(gotL, gotD);
    check("flush_pre_busy", 32'(slot_busy), 32'b011);
    check("flush_pre_cd", 32'(cooldown_active), 32'd1);
    game_active = 1'b0; step(); game_active = 1'b1;
    check("flush_cd", 32'(cooldown_active), 32'd0);
    check("flush_busy", 32'(slot_busy), 32'd0);
    check("flush_ammo", 32'(ammo), 32'd3);
    step();

    // key held across game start does not fire
    game_active = 1'b0; keycode = 16'h2C00; step(); step();
    game_active = 1'b1; nLaunch = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (launch != 3'b000 || dry_fire) nLaunch++;
    end
    check("held_over_start", 32'(nLaunch), 32'd0);
    keycode = 16'h0000; step();

    // asynchronous reset in the middle of FIRE
    keycode = 16'h002C; step();
    check("midfire_launch", 32'(launch), 32'b001);
    Reset = 1'b0; #1;
    check("midfire_rst_launch", 32'(launch), 32'd0);
    check("midfire_rst_busy", 32'(slot_busy), 32'd0);
    check("midfire_rst_ammo", 32'(ammo), 32'd3);
    step(); step();
    Reset = 1'b1; keycode = 16'h0000; step();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3, 0) == 0) begin
        case ($urandom_range(3, 0))
          0: keycode = 16'h0000;
          1: keycode = {8'h2C, 8'($urandom)};
          2: keycode = {8'($urandom), 8'h2C};
          default: keycode = 16'h1D23;
        endcase
      end
      frame_tick  = ($urandom_range(2, 0) == 0);
      game_active = ($urandom_range(63, 0) != 0);
      slot_done   = ($urandom_range(5, 0) == 0) ? 3'($urandom) : 3'b000;
      motionFlag  = 2'($urandom);
      Reset       = ($urandom_range(499, 0) != 0);
      step();
    end
    Reset = 1'b1; game_active = 1'b1; frame_tick = 1'b0; slot_done = 3'b000;
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
